// File: rtl/gene_decomp_ctrl_if.sv
// -----------------------------------------------------------------------------
// gene_decomp_ctrl_if
// Stream bundle for the 2-bit-per-base decompression controller.
//
// Signals:
//   in_data   [7:0]  packed byte; bits[7:6] = first base, bits[1:0] = fourth
//   in_valid         producer has a byte on in_data
//   in_ready         controller takes in_data this cycle
//   out_char  [7:0]  ASCII nucleotide
//   out_valid        out_char is valid
//   out_ready        sink takes out_char this cycle
//   out_last         out_char is the final base of the job
//
// Modports:
//   master  environment side (byte producer + character sink)
//   slave   controller side (gene_decomp_ctrl)
// -----------------------------------------------------------------------------
interface gene_decomp_ctrl_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_char;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_char, out_valid, out_last
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_char, out_valid, out_last
    );
endinterface

// File: rtl/gene_decomp_ctrl.sv
// -----------------------------------------------------------------------------
// gene_decomp_ctrl
// Sequencing controller for the 2-bit-per-base decompression path. Each packed
// byte taken from the input stream expands into up to four ASCII bases
// (00->'A', 01->'C', 10->'G', 11->'T'), most significant pair first. A job is
// started with a length in bases; the final base is flagged with out_last and
// the end of the job is marked with a one-cycle done pulse.
//
// Parameters:
//   CNT_W       width of the base counter and base_count port
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       one-cycle pulse, begins a job when idle
//   abort       synchronous abort back to idle, no done pulse
//   base_count  job length in bases, sampled with start
//   bus         stream bundle (slave modport): byte input, character output
//   busy        high whenever the controller is not idle
//   done        one-cycle pulse at the end of a job
//   stall_cnt   [15:0] saturating stall-cycle counter, present only when
//               GENE_DECOMP_STALL_CNT_EN is defined
//
// Optional feature macro: GENE_DECOMP_STALL_CNT_EN
// -----------------------------------------------------------------------------
module gene_decomp_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] base_count,
    gene_decomp_ctrl_if.slave bus,
    output logic             busy,
    output logic             done
`ifdef GENE_DECOMP_STALL_CNT_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EMIT,
        FIN
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] remaining;
    logic [1:0]       slot;
    logic [7:0]       data_q;

    // Translate one 2-bit base code into its ASCII letter.
    function automatic logic [7:0] code_map(input logic [1:0] code);
        case (code)
            2'b00:   code_map = 8'h41;
            2'b01:   code_map = 8'h43;
            2'b10:   code_map = 8'h47;
            default: code_map = 8'h54;
        endcase
    endfunction

    // Pick the base pair for a slot; slot 0 is the most significant pair.
    function automatic logic [1:0] pair_at(input logic [7:0] data, input logic [1:0] idx);
        case (idx)
            2'd0:    pair_at = data[7:6];
            2'd1:    pair_at = data[5:4];
            2'd2:    pair_at = data[3:2];
            default: pair_at = data[1:0];
        endcase
    endfunction

    // Main sequencer. Every output is a register loaded with the value it
    // must carry in the state being entered, so nothing downstream sees a
    // combinational path from the handshake inputs. Abort has priority over
    // everything, including a byte handshaken in the same cycle, which is
    // simply dropped. A zero-length job spends one quiet cycle in FIN before
    // raising done; a job that emitted bases raises done on entry to FIN, so
    // done always directly follows the final beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            remaining     <= '0;
            slot          <= 2'd0;
            data_q        <= 8'h00;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.out_char  <= 8'h00;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else if (abort) begin
            state         <= IDLE;
            remaining     <= '0;
            slot          <= 2'd0;
            data_q        <= 8'h00;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.out_char  <= 8'h00;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (base_count == '0) begin
                            state <= FIN;
                            done  <= 1'b0;
                        end else begin
                            remaining    <= base_count;
                            state        <= FETCH;
                            bus.in_ready <= 1'b1;
                        end
                    end
                end

                FETCH: begin
                    if (bus.in_valid) begin
                        data_q        <= bus.in_data;
                        slot          <= 2'd0;
                        state         <= EMIT;
                        bus.in_ready  <= 1'b0;
                        bus.out_valid <= 1'b1;
                        bus.out_char  <= code_map(bus.in_data[7:6]);
                        bus.out_last  <= (remaining == CNT_W'(1));
                    end
                end

                EMIT: begin
                    if (bus.out_ready) begin
                        remaining <= remaining - CNT_W'(1);
                        slot      <= slot + 2'd1;
                        if (remaining == CNT_W'(1)) begin
                            state         <= FIN;
                            bus.out_valid <= 1'b0;
                            bus.out_last  <= 1'b0;
                            bus.out_char  <= 8'h00;
                            done          <= 1'b1;
                        end else if (slot == 2'd3) begin
                            state         <= FETCH;
                            bus.out_valid <= 1'b0;
                            bus.out_last  <= 1'b0;
                            bus.out_char  <= 8'h00;
                            bus.in_ready  <= 1'b1;
                        end else begin
                            bus.out_char <= code_map(pair_at(data_q, slot + 2'd1));
                            bus.out_last <= (remaining == CNT_W'(2));
                        end
                    end
                end

                FIN: begin
                    if (done) begin
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        done <= 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

`ifdef GENE_DECOMP_STALL_CNT_EN
    // Stall counter: counts cycles where the controller is waiting on the
    // producer (fetching with no byte offered) or on the sink (base held
    // with no ready). It restarts with each accepted job and sticks at the
    // top value instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 16'h0000;
        end else if (state == IDLE && start && !abort) begin
            stall_cnt <= 16'h0000;
        end else if (((state == FETCH && !bus.in_valid) ||
                      (state == EMIT && !bus.out_ready)) &&
                     stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gene_decomp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gene_decomp_ctrl
// Scoreboard bench for gene_decomp_ctrl. Each job's expected character stream
// is derived from the packed bytes with plain arithmetic and queued; a monitor
// pops and compares on every accepted output beat. Directed jobs cover the
// basic expansion, partial last byte, backpressure, zero length, abort and
// asynchronous reset; randomized jobs add input gaps and random backpressure.
// -----------------------------------------------------------------------------
module tb_gene_decomp_ctrl;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [CNT_W-1:0] base_count = '0;
    logic             busy;
    logic             done;
`ifdef GENE_DECOMP_STALL_CNT_EN
    logic [15:0]      stall_cnt;
`endif

    gene_decomp_ctrl_if bus();

    gene_decomp_ctrl #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .base_count (base_count),
        .bus        (bus),
        .busy       (busy),
        .done       (done)
`ifdef GENE_DECOMP_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [8:0] expQ[$];
    logic [7:0] feedQ[$];
    logic [7:0] jobBytes[$];

    int cycle = 0;
    int beatCount = 0;
    int byteCount = 0;
    int inReadyCycles = 0;
    int outValidCycles = 0;
    int doneCount = 0;
    int doneCycle = 0;
    int stallBeat = -1;
    int stallLeft = 0;
    bit gapsOn = 1'b0;
    bit randReady = 1'b0;
    bit feedPop = 1'b0;
    bit holdPrev = 1'b0;
    bit lastPrev = 1'b0;
    logic [7:0] prevChar = 8'h00;
    logic       prevLast = 1'b0;

    // Shared comparison: counts every check and reports each miss on one line.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, wanted %0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Reference model: base i of the job is pair (i mod 4) of byte i/4,
    // counted from the top of the byte, spelled out via the letter table.
    task automatic loadJob(input int n);
        string bases;
        int    nb;
        bases = "ACGT";
        nb = (n + 3) / 4;
        for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            int         code;
            b = jobBytes[i / 4];
            code = int'(b >> (6 - 2 * (i % 4))) & 3;
            expQ.push_back({(i == n - 1), bases[code]});
        end
        for (int j = 0; j < nb; j++) feedQ.push_back(jobBytes[j]);
    endtask

    // Producer/sink driver: updates inputs 1 time unit after each rising edge.
    always @(posedge clk) begin
        cycle++;
        #1;
        if (feedPop && feedQ.size() > 0) feedQ.delete(0);
        feedPop = 1'b0;
        if (feedQ.size() > 0 && (!gapsOn || $urandom_range(0, 2) != 0)) begin
            bus.in_valid = 1'b1;
            bus.in_data  = feedQ[0];
        end else begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
        end
        if (stallLeft > 0 && beatCount == stallBeat) begin
            bus.out_ready = 1'b0;
            stallLeft--;
        end else begin
            bus.out_ready = randReady ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Monitor: samples on the falling edge, pops the scoreboard on every
    // accepted beat, checks holding under backpressure and done placement.
    always @(negedge clk) begin
        if (!rst_n) begin
            holdPrev = 1'b0;
            lastPrev = 1'b0;
            feedPop  = 1'b0;
        end else begin
            logic [8:0] exp;
            if (bus.in_ready) inReadyCycles++;
            if (bus.out_valid) outValidCycles++;
            if (holdPrev) begin
                checkOutput("hold_valid", 32'(bus.out_valid), 32'd1);
                checkOutput("hold_char", 32'(bus.out_char), 32'(prevChar));
                checkOutput("hold_last", 32'(bus.out_last), 32'(prevLast));
            end
            holdPrev = bus.out_valid && !bus.out_ready && !abort;
            prevChar = bus.out_char;
            prevLast = bus.out_last;
            if (lastPrev) checkOutput("done_after_last", 32'(done), 32'd1);
            lastPrev = 1'b0;
            if (bus.out_valid && bus.out_ready) begin
                beatCount++;
                exp = (expQ.size() > 0) ? expQ.pop_front() : 9'h1FF;
                checkOutput("beat", 32'({bus.out_last, bus.out_char}), 32'(exp));
                lastPrev = bus.out_last && !abort;
            end
            if (bus.in_valid && bus.in_ready) begin
                byteCount++;
                feedPop = 1'b1;
            end
            if (done) begin
                doneCount++;
                doneCycle = cycle;
            end
        end
    end

    // Run one job from start to done and check its totals and timing.
    // Entered and left at 2 time units after a rising edge.
    task automatic applyStimulus(input int n, input bit randMode, input int stallB,
                                 input int stallN, input bit midStart);
        int nb;
        int startCycle;
        int doneSeen;
        int expLat;
        nb = (n + 3) / 4;
        expLat = (n == 0) ? 2 : nb + n + 1 + stallN;
        loadJob(n);
        beatCount = 0;
        byteCount = 0;
        inReadyCycles = 0;
        outValidCycles = 0;
        doneSeen = doneCount;
        gapsOn = randMode;
        randReady = randMode;
        stallBeat = stallB;
        stallLeft = stallN;
        startCycle = cycle;
        start = 1'b1;
        base_count = CNT_W'(n);
        for (int w = 0; w < 500 && doneCount == doneSeen; w++) begin
            @(posedge clk);
            #2;
            if (w == 0) checkOutput("busy_after_start", 32'(busy), 32'd1);
            start = midStart && (w == 1);
            if (start) base_count = CNT_W'(2);
        end
        start = 1'b0;
        checkOutput("done_count", 32'(doneCount - doneSeen), 32'd1);
        checkOutput("done_one_cycle", 32'(done), 32'd0);
        checkOutput("idle_after_done", 32'(busy), 32'd0);
        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
        checkOutput("bytes_consumed", 32'(byteCount), 32'(nb));
        checkOutput("feed_drained", 32'(feedQ.size()), 32'd0);
        if (!randMode) begin
            checkOutput("latency", 32'(doneCycle - startCycle), 32'(expLat));
            checkOutput("in_ready_cycles", 32'(inReadyCycles), 32'(nb));
        end
        if (n == 0) checkOutput("no_out_valid", 32'(outValidCycles), 32'd0);
`ifdef GENE_DECOMP_STALL_CNT_EN
        if (stallN > 0) checkOutput("stall_cnt", 32'(stall_cnt), 32'(stallN));
`endif
        gapsOn = 1'b0;
        randReady = 1'b0;
        stallBeat = -1;
        stallLeft = 0;
    endtask

    // Wait (bounded) until the monitor has seen a number of beats.
    task automatic waitBeats(input int target);
        for (int w = 0; w < 200 && beatCount < target; w++) begin
            @(posedge clk);
            #2;
        end
        checkOutput("beats_reached", 32'(beatCount >= target), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed and random scenarios.
    initial begin
        int doneBefore;
        int n;
        bus.in_data = 8'h00;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_out_last", 32'(bus.out_last), 32'd0);
        checkOutput("rst_out_char", 32'(bus.out_char), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        $display("[TB] one full byte");
        jobBytes = {8'b00011110};
        applyStimulus(4, 1'b0, -1, 0, 1'b0);

        $display("[TB] partial last byte");
        jobBytes = {8'hFF, 8'h1B};
        applyStimulus(6, 1'b0, -1, 0, 1'b0);

        $display("[TB] backpressure on second beat");
        jobBytes = {8'h1B};
        applyStimulus(4, 1'b0, 1, 3, 1'b0);

        $display("[TB] zero-length job");
        jobBytes.delete();
        applyStimulus(0, 1'b0, -1, 0, 1'b0);

        $display("[TB] start and abort together while idle");
        doneBefore = doneCount;
        start = 1'b1;
        abort = 1'b1;
        base_count = CNT_W'(4);
        @(posedge clk);
        #2;
        start = 1'b0;
        abort = 1'b0;
        checkOutput("abort_wins_busy", 32'(busy), 32'd0);
        checkOutput("abort_wins_in_ready", 32'(bus.in_ready), 32'd0);
        repeat (3) @(posedge clk);
        #2;
        checkOutput("abort_wins_no_done", 32'(doneCount - doneBefore), 32'd0);

        $display("[TB] abort mid job");
        jobBytes = {8'($urandom), 8'($urandom)};
        loadJob(8);
        beatCount = 0;
        doneBefore = doneCount;
        start = 1'b1;
        base_count = CNT_W'(8);
        @(posedge clk);
        #2;
        start = 1'b0;
        waitBeats(2);
        abort = 1'b1;
        @(posedge clk);
        #2;
        abort = 1'b0;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("abort_out_char", 32'(bus.out_char), 32'd0);
        checkOutput("abort_in_ready", 32'(bus.in_ready), 32'd0);
        expQ.delete();
        feedQ.delete();
        repeat (5) @(posedge clk);
        #2;
        checkOutput("abort_no_done", 32'(doneCount - doneBefore), 32'd0);

        $display("[TB] single base after abort");
        jobBytes = {8'h80};
        applyStimulus(1, 1'b0, -1, 0, 1'b0);

        $display("[TB] randomized jobs");
        for (int r = 0; r < 10; r++) begin
            n = $urandom_range(1, 23);
            jobBytes.delete();
            for (int k = 0; k < (n + 3) / 4; k++) jobBytes.push_back(8'($urandom));
            applyStimulus(n, 1'b1, -1, 0, (r % 3) == 0);
        end

        $display("[TB] reset mid emit");
        jobBytes = {8'($urandom), 8'($urandom)};
        loadJob(8);
        beatCount = 0;
        doneBefore = doneCount;
        start = 1'b1;
        base_count = CNT_W'(8);
        @(posedge clk);
        #2;
        start = 1'b0;
        waitBeats(1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_busy", 32'(busy), 32'd0);
        checkOutput("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("async_rst_out_char", 32'(bus.out_char), 32'd0);
        checkOutput("async_rst_out_last", 32'(bus.out_last), 32'd0);
        checkOutput("async_rst_in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("async_rst_done", 32'(done), 32'd0);
        expQ.delete();
        feedQ.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        checkOutput("reset_no_done", 32'(doneCount - doneBefore), 32'd0);
        jobBytes = {8'($urandom), 8'($urandom)};
        applyStimulus(5, 1'b0, -1, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
